lc3_execute: RTL

- Execute stage of the LC-3 pipeline, directly downstream of the decode stage.
- Consumes the decoded instruction word, its next-PC and the packed E/M/W control fields.
- Selects operands, with ALU and memory-value bypass, then computes the ALU result, the effective/branch address and the branch NZP mask.
- Registers all results for the writeback and memory stages.

---
 rtl/lc3_pkg.sv | 41 ++++
 rtl/lc3_alu.sv | 25 ++
 rtl/lc3_execute.sv | 125 ++++++++++++
 3 files changed

// File: rtl/lc3_pkg.sv
// lc3_pkg: shared definitions for the LC-3 execute slice.
//   - opcode constants (IR[15:12])
//   - E_Control field bit positions
//   - ALU function and writeback-source encodings
package lc3_pkg;

  localparam logic [3:0] OP_BR  = 4'h0;
  localparam logic [3:0] OP_ADD = 4'h1;
  localparam logic [3:0] OP_LD  = 4'h2;
  localparam logic [3:0] OP_ST  = 4'h3;
  localparam logic [3:0] OP_AND = 4'h5;
  localparam logic [3:0] OP_LDR = 4'h6;
  localparam logic [3:0] OP_STR = 4'h7;
  localparam logic [3:0] OP_NOT = 4'h9;
  localparam logic [3:0] OP_LDI = 4'hA;
  localparam logic [3:0] OP_STI = 4'hB;
  localparam logic [3:0] OP_JMP = 4'hC;
  localparam logic [3:0] OP_LEA = 4'hE;

  // E_Control = {alu_control[5:4], pcselect1[3:2], pcselect2[1], op2select[0]}
  localparam int EC_ALU_HI  = 5;
  localparam int EC_ALU_LO  = 4;
  localparam int EC_PCS1_HI = 3;
  localparam int EC_PCS1_LO = 2;
  localparam int EC_PCS2    = 1;
  localparam int EC_OP2SEL  = 0;

  typedef enum logic [1:0] {
    ALU_ADD  = 2'd0,
    ALU_AND  = 2'd1,
    ALU_NOT  = 2'd2,
    ALU_ZERO = 2'd3
  } alu_op_e;

  typedef enum logic [1:0] {
    WB_ALU = 2'd0,
    WB_MEM = 2'd1,
    WB_PC  = 2'd2
  } wb_sel_e;

endpackage

// File: rtl/lc3_alu.sv
// lc3_alu: combinational 16-bit ALU for the execute stage.
//   a_i, b_i : operands
//   op_i     : function (ADD / AND / NOT a / zero)
//   y_o      : result, ADD wraps modulo 2^16
module lc3_alu
  import lc3_pkg::*;
(
  input  logic [15:0] a_i,
  input  logic [15:0] b_i,
  input  alu_op_e     op_i,
  output logic [15:0] y_o
);

  always_comb begin
    y_o = '0;
    unique case (op_i)
      ALU_ADD:  y_o = a_i + b_i;
      ALU_AND:  y_o = a_i & b_i;
      ALU_NOT:  y_o = ~a_i;
      ALU_ZERO: y_o = '0;
      default:  y_o = '0;
    endcase
  end

endmodule

// File: rtl/lc3_execute.sv
// lc3_execute: LC-3 execute stage.
//   Resolves operands (ALU bypass > memory bypass > register file), runs the
//   ALU, forms the PC-relative / base+offset address and the branch NZP mask,
//   and registers everything for the memory/writeback stages.
//   Inputs : clock, reset (sync, active-high), enable_execute, E_Control, IR,
//            npc_in, W_Control_in, Mem_Control_in, VSR1/VSR2, bypass_*,
//            Mem_Bypass_Val
//   Outputs: aluout, pcout, M_Data, NZP, dr, W_Control_out, Mem_Control_out,
//            IR_Exec (registered); sr1, sr2 (combinational from IR)
module lc3_execute
  import lc3_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        enable_execute,
  input  logic [5:0]  E_Control,
  input  logic [15:0] IR,
  input  logic [15:0] npc_in,
  input  logic [1:0]  W_Control_in,
  input  logic        Mem_Control_in,
  input  logic [15:0] VSR1,
  input  logic [15:0] VSR2,
  input  logic        bypass_alu_1,
  input  logic        bypass_alu_2,
  input  logic        bypass_mem_1,
  input  logic        bypass_mem_2,
  input  logic [15:0] Mem_Bypass_Val,
  output logic [15:0] aluout,
  output logic [15:0] pcout,
  output logic [15:0] M_Data,
  output logic [2:0]  NZP,
  output logic [2:0]  dr,
  output logic [1:0]  W_Control_out,
  output logic        Mem_Control_out,
  output logic [15:0] IR_Exec,
  output logic [2:0]  sr1,
  output logic [2:0]  sr2
);

  logic [15:0] aluout_q, pcout_q, mdata_q, ir_q;
  logic [2:0]  nzp_q, dr_q;
  logic [1:0]  wctl_q;
  logic        mctl_q;

  logic [3:0]  opcode;
  logic [1:0]  pcs1;
  logic        pcs2, op2sel;
  alu_op_e     alu_op;
  logic [15:0] op1, op2, alu_b, alu_y, addend1, addend2;
  logic [2:0]  nzp_d;

  assign opcode = IR[15:12];
  assign pcs1   = E_Control[EC_PCS1_HI:EC_PCS1_LO];
  assign pcs2   = E_Control[EC_PCS2];
  assign op2sel = E_Control[EC_OP2SEL];
  assign alu_op = alu_op_e'(E_Control[EC_ALU_HI:EC_ALU_LO]);

  // Stores read the data register from the dr field.
  assign sr1 = IR[8:6];
  assign sr2 = (opcode == OP_ST || opcode == OP_STR || opcode == OP_STI) ? IR[11:9] : IR[2:0];

  // ALU bypass reads our own registered result, so a dependent ALU op
  // issued next cycle needs no stall.
  assign op1 = bypass_alu_1 ? aluout_q : (bypass_mem_1 ? Mem_Bypass_Val : VSR1);
  assign op2 = bypass_alu_2 ? aluout_q : (bypass_mem_2 ? Mem_Bypass_Val : VSR2);

  assign alu_b = op2sel ? op2 : {{11{IR[4]}}, IR[4:0]};

  lc3_alu u_alu (
    .a_i (op1),
    .b_i (alu_b),
    .op_i(alu_op),
    .y_o (alu_y)
  );

  always_comb begin
    addend1 = '0;
    unique case (pcs1)
      2'd0:    addend1 = {{5{IR[10]}}, IR[10:0]};
      2'd1:    addend1 = {{7{IR[8]}}, IR[8:0]};
      2'd2:    addend1 = {{10{IR[5]}}, IR[5:0]};
      default: addend1 = '0;
    endcase
  end

  assign addend2 = pcs2 ? npc_in : op1;

  always_comb begin
    nzp_d = 3'b000;
    if (opcode == OP_BR)       nzp_d = IR[11:9];
    else if (opcode == OP_JMP) nzp_d = 3'b111;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      aluout_q <= '0;
      pcout_q  <= '0;
      mdata_q  <= '0;
      nzp_q    <= '0;
      dr_q     <= '0;
      wctl_q   <= '0;
      mctl_q   <= 1'b0;
      ir_q     <= '0;
    end else if (enable_execute) begin
      aluout_q <= alu_y;
      pcout_q  <= addend1 + addend2;
      mdata_q  <= op2;
      nzp_q    <= nzp_d;
      dr_q     <= IR[11:9];
      wctl_q   <= W_Control_in;
      mctl_q   <= Mem_Control_in;
      ir_q     <= IR;
    end
  end

  assign aluout          = aluout_q;
  assign pcout           = pcout_q;
  assign M_Data          = mdata_q;
  assign NZP             = nzp_q;
  assign dr              = dr_q;
  assign W_Control_out   = wctl_q;
  assign Mem_Control_out = mctl_q;
  assign IR_Exec         = ir_q;

endmodule
